rom_download_ctl: RTL

ROM_DOWNLOAD_CTL -- requirements
Module: rom_download_ctl

---
 rtl/rom_download_ctl_pkg.sv | 22 ++
 rtl/rom_download_ctl_decode.sv | 41 ++++
 rtl/rom_download_ctl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rom_download_ctl_pkg.sv
// Shared types and memory-map constants for the ROM/PROM download controller.
package rom_download_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [24:0]  ROM_BASE       = 25'h000_0000;
    localparam int unsigned  ROM_CHIP_SIZE  = 32'h800;
    localparam int unsigned  PROM_CHIP_SIZE = 32'h100;

    // PROMs sit directly after the last program ROM.
    function automatic logic [24:0] prom_base(input int unsigned rom_chips);
        return 25'(rom_chips * ROM_CHIP_SIZE);
    endfunction

endpackage

// File: rtl/rom_download_ctl_decode.sv
// Combinational image-offset decode: chip one-hot select and chip-local address.
module rom_region_decode
    import rom_download_ctl_pkg::*;
#(
    parameter int ROM_CHIPS  = 8,
    parameter int PROM_CHIPS = 2
) (
    input  logic [24:0]           offset,
    output logic [ROM_CHIPS-1:0]  rom_sel,
    output logic [PROM_CHIPS-1:0] prom_sel,
    output logic [10:0]           local_addr
);

    localparam logic [24:0] ROM_END   = ROM_BASE + 25'(ROM_CHIPS * ROM_CHIP_SIZE);
    localparam logic [24:0] PROM_BASE = prom_base(ROM_CHIPS);
    localparam logic [24:0] PROM_END  = PROM_BASE + 25'(PROM_CHIPS * PROM_CHIP_SIZE);

    logic [24:0] rom_off;
    logic [24:0] prom_off;

    always_comb begin
        rom_sel    = '0;
        prom_sel   = '0;
        local_addr = '0;
        rom_off    = offset - ROM_BASE;
        prom_off   = offset - PROM_BASE;
        if (offset < ROM_END) begin
            for (int i = 0; i < ROM_CHIPS; i++) begin
                if (rom_off[24:11] == 14'(i)) rom_sel[i] = 1'b1;
            end
            local_addr = rom_off[10:0];
        end else if (offset < PROM_END) begin
            for (int i = 0; i < PROM_CHIPS; i++) begin
                if (prom_off[24:8] == 17'(i)) prom_sel[i] = 1'b1;
            end
            local_addr = {3'b000, prom_off[7:0]};
        end
        // Offsets beyond the map leave every select low.
    end

endmodule

// File: rtl/rom_download_ctl.sv
// Host ioctl download controller: writes a ROM/PROM image into program ports,
// paces the host with ioctl_wait and validates the image length.
//
//   state    | meaning
//   IDLE     | no download seen since reset
//   LOAD     | download open, waiting for the next byte
//   WRITE    | one write enable pulse to the selected chip
//   CHECK    | download closed, judging length and overrun
//   DONE     | image complete and valid
//   ERROR    | image short or a byte was dropped
module rom_download_ctl
    import rom_download_ctl_pkg::*;
#(
    parameter int          ROM_CHIPS  = 8,
    parameter int          PROM_CHIPS = 2,
    parameter logic [7:0]  LOAD_INDEX = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  ioctl_wr,
    output logic                  ioctl_wait,
    output logic [10:0]           rom_addr,
    output logic [7:0]            rom_data,
    output logic [ROM_CHIPS-1:0]  rom_we,
    output logic [7:0]            prom_addr,
    output logic [7:0]            prom_data,
    output logic [PROM_CHIPS-1:0] prom_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           checksum
);

    localparam logic [16:0] IMAGE_MIN =
        17'(ROM_CHIPS * ROM_CHIP_SIZE + PROM_CHIPS * PROM_CHIP_SIZE);

    state_t                  state;
    logic                    qual_q;
    logic                    overrun;
    logic [15:0]             byte_count;

    logic                    qual;
    logic                    acc_wr;
    logic [ROM_CHIPS-1:0]    rom_sel;
    logic [PROM_CHIPS-1:0]   prom_sel;
    logic [10:0]             local_addr;

    assign qual   = ioctl_download && (ioctl_index == LOAD_INDEX);
    assign acc_wr = qual && ioctl_wr;

    rom_region_decode #(
        .ROM_CHIPS  (ROM_CHIPS),
        .PROM_CHIPS (PROM_CHIPS)
    ) u_decode (
        .offset     (ioctl_addr),
        .rom_sel    (rom_sel),
        .prom_sel   (prom_sel),
        .local_addr (local_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            qual_q     <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
            ioctl_wait <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            rom_we     <= '0;
            prom_addr  <= '0;
            prom_data  <= '0;
            prom_we    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
        end else begin
            qual_q  <= qual;
            rom_we  <= '0;
            prom_we <= '0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (qual && !qual_q) begin
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        overrun    <= 1'b0;
                        checksum   <= '0;
                        byte_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        state      <= ST_CHECK;
                        ioctl_wait <= 1'b0;
                    end else if (ioctl_wait) begin
                        // Second wait cycle: a strobe here violates the handshake.
                        ioctl_wait <= 1'b0;
                        if (acc_wr) begin
                            overrun <= 1'b1;
                            error   <= 1'b1;
                        end
                    end else if (acc_wr) begin
                        state      <= ST_WRITE;
                        ioctl_wait <= 1'b1;
                        rom_we     <= rom_sel;
                        prom_we    <= prom_sel;
                        rom_addr   <= local_addr;
                        prom_addr  <= local_addr[7:0];
                        rom_data   <= ioctl_dout;
                        prom_data  <= ioctl_dout;
                        checksum   <= checksum + {8'h00, ioctl_dout};
                        if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
                    end
                end
                ST_WRITE: begin
                    state <= ST_LOAD;
                    if (acc_wr) begin
                        overrun <= 1'b1;
                        error   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (({1'b0, byte_count} >= IMAGE_MIN) && !overrun) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
